// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_arb_state_t;

  typedef logic req_id_t;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int DEFAULT_DATA_W = 64;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way grant. Defining MEM_ARB_FIXED_PRIO_EN gives requester 1
// priority on ties; otherwise ties go to the requester that was not granted last.
import mem_arb_pkg::*;

module rr_arbiter2 (
  input  logic    valid0,
  input  logic    valid1,
  input  req_id_t last_grant,
  output logic    grant_valid,
  output req_id_t grant
);

  always_comb begin
    grant_valid = valid0 | valid1;
    grant       = 1'b0;
    if (valid0 && valid1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      grant = 1'b1;
`else
      grant = ~last_grant;
`endif
    end else if (valid1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one single-port memory between fetch (id 0) and load/store (id 1).
// Arbitration mode is selected in rr_arbiter2 via MEM_ARB_FIXED_PRIO_EN.
import mem_arb_pkg::*;

module memory_arbiter #(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0Valid,
  input  logic              req1Valid,
  output logic              req0Ready,
  output logic              req1Ready,
  input  logic [ADDR_W-1:0] req0Addr,
  input  logic [ADDR_W-1:0] req1Addr,
  input  logic [DATA_W-1:0] req0WData,
  input  logic [DATA_W-1:0] req1WData,
  input  logic              req0WrEn,
  input  logic              req1WrEn,
  output logic              rsp0Valid,
  output logic              rsp1Valid,
  output logic [DATA_W-1:0] rspRData,
  output logic [ADDR_W-1:0] memAddress,
  output logic [DATA_W-1:0] memWriteData,
  output logic              memWriteEn,
  input  logic [DATA_W-1:0] memReadData
);

  mem_arb_state_t    state, next_state;
  req_id_t           last_grant, grant, cap_id;
  logic              grant_valid, accept;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_wr;

  rr_arbiter2 u_arb (
    .valid0      (req0Valid),
    .valid1      (req1Valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          accept     = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign req0Ready = accept && (grant == 1'b0);
  assign req1Ready = accept && (grant == 1'b1);

  // Write enable is gated by the state register, so an async reset kills it at once.
  assign memAddress   = cap_addr;
  assign memWriteData = cap_wdata;
  assign memWriteEn   = (state == ACCESS) && cap_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr   <= '0;
      cap_wdata  <= '0;
      cap_wr     <= 1'b0;
      cap_id     <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      cap_addr   <= (grant == 1'b1) ? req1Addr  : req0Addr;
      cap_wdata  <= (grant == 1'b1) ? req1WData : req0WData;
      cap_wr     <= (grant == 1'b1) ? req1WrEn  : req0WrEn;
      cap_id     <= grant;
      last_grant <= grant;
    end
  end

  // Read data is sampled before the write lands, so write acks return old contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rspRData  <= '0;
      rsp0Valid <= 1'b0;
      rsp1Valid <= 1'b0;
    end else begin
      rsp0Valid <= (state == ACCESS) && (cap_id == 1'b0);
      rsp1Valid <= (state == ACCESS) && (cap_id == 1'b1);
      if (state == ACCESS) rspRData <= memReadData;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed self-checking bench for memory_arbiter with a behavioral memory.
// Build with MEM_ARB_FIXED_PRIO_EN to exercise fixed-priority expectations.
module tb_memory_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0Valid, req1Valid, req0Ready, req1Ready;
  logic [ADDR_W-1:0] req0Addr, req1Addr;
  logic [DATA_W-1:0] req0WData, req1WData;
  logic              req0WrEn, req1WrEn;
  logic              rsp0Valid, rsp1Valid;
  logic [DATA_W-1:0] rspRData;
  logic [ADDR_W-1:0] memAddress;
  logic [DATA_W-1:0] memWriteData;
  logic              memWriteEn;
  logic [DATA_W-1:0] memReadData;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign memReadData = mem[memAddress];
  always @(posedge clk) if (memWriteEn) mem[memAddress] <= memWriteData;

  memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0Valid(req0Valid), .req1Valid(req1Valid),
    .req0Ready(req0Ready), .req1Ready(req1Ready),
    .req0Addr(req0Addr), .req1Addr(req1Addr),
    .req0WData(req0WData), .req1WData(req1WData),
    .req0WrEn(req0WrEn), .req1WrEn(req1WrEn),
    .rsp0Valid(rsp0Valid), .rsp1Valid(rsp1Valid),
    .rspRData(rspRData),
    .memAddress(memAddress), .memWriteData(memWriteData),
    .memWriteEn(memWriteEn), .memReadData(memReadData)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [ADDR_W-1:0] a0,
                               input logic [DATA_W-1:0] d0, input logic w0,
                               input logic v1, input logic [ADDR_W-1:0] a1,
                               input logic [DATA_W-1:0] d1, input logic w1);
    req0Valid = v0; req0Addr = a0; req0WData = d0; req0WrEn = w0;
    req1Valid = v1; req1Addr = a1; req1WData = d1; req1WrEn = w1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int g;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem[0] = 64'hA0;
    mem[1] = 64'hB1;
    rst_n = 1'b0;
    idleInputs();

    // Reset values
    checkOutput("rst_req0Ready", {63'd0, req0Ready}, 64'd0);
    checkOutput("rst_req1Ready", {63'd0, req1Ready}, 64'd0);
    checkOutput("rst_rsp0Valid", {63'd0, rsp0Valid}, 64'd0);
    checkOutput("rst_rspRData", rspRData, 64'd0);
    checkOutput("rst_memAddress", {56'd0, memAddress}, 64'd0);
    checkOutput("rst_memWriteEn", {63'd0, memWriteEn}, 64'd0);
    step();
    rst_n = 1'b1;

    // Requester 0 alone: write addr 3 then read it back
    applyStimulus(1'b1, 8'd3, 64'h33, 1'b1, 1'b0, '0, '0, 1'b0);
    checkOutput("t1_wr_ready", {63'd0, req0Ready}, 64'd1);
    step();
    idleInputs();
    checkOutput("t1_access_we", {63'd0, memWriteEn}, 64'd1);
    checkOutput("t1_access_addr", {56'd0, memAddress}, 64'd3);
    checkOutput("t1_access_noready", {63'd0, req0Ready}, 64'd0);
    step();
    checkOutput("t1_wrack_valid", {63'd0, rsp0Valid}, 64'd1);
    checkOutput("t1_wrack_data", rspRData, 64'd0);
    checkOutput("t1_idle_we", {63'd0, memWriteEn}, 64'd0);
    applyStimulus(1'b1, 8'd3, 64'h0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkOutput("t1_rd_ready", {63'd0, req0Ready}, 64'd1);
    step();
    idleInputs();
    checkOutput("t1_rd_gap", {63'd0, rsp0Valid}, 64'd0);
    step();
    checkOutput("t1_rd_valid", {63'd0, rsp0Valid}, 64'd1);
    checkOutput("t1_rd_data", rspRData, 64'h33);

    // Contention from reset: round-robin grants, or all to 1 under fixed priority
    rst_n = 1'b0;
    #1;
    step();
    rst_n = 1'b1;
    applyStimulus(1'b1, 8'd0, '0, 1'b0, 1'b1, 8'd1, '0, 1'b0);
    for (int i = 0; i < 6; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      g = 1;
`else
      g = i % 2;
`endif
      checkOutput($sformatf("t2_ready0_%0d", i), {63'd0, req0Ready}, (g == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t2_ready1_%0d", i), {63'd0, req1Ready}, (g == 1) ? 64'd1 : 64'd0);
      step();
      checkOutput($sformatf("t2_access_noready_%0d", i), {62'd0, req0Ready, req1Ready}, 64'd0);
      step();
      checkOutput($sformatf("t2_rsp0_%0d", i), {63'd0, rsp0Valid}, (g == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t2_rsp1_%0d", i), {63'd0, rsp1Valid}, (g == 1) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t2_data_%0d", i), rspRData, (g == 0) ? 64'hA0 : 64'hB1);
    end
    idleInputs();
    step();
    step();

    // Requester 1 writes addr 5, requester 0 then reads it
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 8'd5, 64'hDEAD, 1'b1);
    checkOutput("t3_wr_ready1", {63'd0, req1Ready}, 64'd1);
    step();
    applyStimulus(1'b1, 8'd5, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    step();
    checkOutput("t3_ack_valid1", {63'd0, rsp1Valid}, 64'd1);
    checkOutput("t3_ack_data", rspRData, 64'd0);
    checkOutput("t3_rd_ready0", {63'd0, req0Ready}, 64'd1);
    step();
    idleInputs();
    step();
    checkOutput("t3_rd_valid0", {63'd0, rsp0Valid}, 64'd1);
    checkOutput("t3_rd_data", rspRData, 64'hDEAD);

    // Reset during the access cycle of a write to addr 7
    applyStimulus(1'b1, 8'd7, 64'hFF, 1'b1, 1'b0, '0, '0, 1'b0);
    step();
    idleInputs();
    checkOutput("t4_we_before", {63'd0, memWriteEn}, 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("t4_we_async_drop", {63'd0, memWriteEn}, 64'd0);
    step();
    checkOutput("t4_no_rsp_a", {62'd0, rsp0Valid, rsp1Valid}, 64'd0);
    rst_n = 1'b1;
    step();
    checkOutput("t4_no_rsp_b", {62'd0, rsp0Valid, rsp1Valid}, 64'd0);
    applyStimulus(1'b1, 8'd7, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    step();
    idleInputs();
    step();
    checkOutput("t4_rd_valid", {63'd0, rsp0Valid}, 64'd1);
    checkOutput("t4_rd_data", rspRData, 64'd0);
    step();

    // req1Valid held: ready only in IDLE cycles, no write enable at all
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 8'd1, '0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      checkOutput($sformatf("t5_ready1_%0d", k), {63'd0, req1Ready}, (k % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t5_rsp1_%0d", k), {63'd0, rsp1Valid},
                  (k % 2 == 0 && k > 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t5_we_%0d", k), {63'd0, memWriteEn}, 64'd0);
      step();
    end
    idleInputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
